pc_phase_seq: RTL

- Multi-cycle instruction sequencer for the 16-bit core.
- Owns the 12-bit PC, the instruction register and the SZCV flag register, and steps each instruction through five one-hot phases: P1 fetch, P2 decode/read, P3 execute, P4 memory, P5 writeback/PC update.
- Drives the jump-calculation block with pc/ir/szcv and consumes its jdest/jflag in P5 to select the next PC.
- Handles run/stop control, the halt instruction and memory wait states.

---
 rtl/pc_phase_seq_pkg.sv | 26 ++
 rtl/pc_phase_seq_phase_ring.sv | 35 +++
 rtl/pc_phase_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/pc_phase_seq_pkg.sv
// Shared constants for the instruction phase sequencer: phase encodings,
// halt opcode pattern and the default PC width.
package pc_phase_seq_pkg;

   localparam int unsigned PC_W_DEF = 12;

   localparam logic [4:0] PH_IDLE = 5'b00000;
   localparam logic [4:0] P1      = 5'b00001;
   localparam logic [4:0] P2      = 5'b00010;
   localparam logic [4:0] P3      = 5'b00100;
   localparam logic [4:0] P4      = 5'b01000;
   localparam logic [4:0] P5      = 5'b10000;

   localparam logic [1:0] OP_HLT_HI = 2'b11;
   localparam logic [3:0] OP_HLT_FN = 4'b1111;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } run_state_e;

   function automatic logic is_halt(input logic [15:0] instr);
      return (instr[15:14] == OP_HLT_HI) && (instr[7:4] == OP_HLT_FN);
   endfunction

endpackage

// File: rtl/pc_phase_seq_phase_ring.sv
// Five-bit one-hot phase ring: clear wins over hold, hold wins over advance.
// Advancing from the all-zero idle value enters P1; P5 wraps back to P1.
module pc_phase_seq_phase_ring
   import pc_phase_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv_i,
   input  logic       hold_i,
   input  logic       clr_i,
   output logic [4:0] phase_o
);

   logic [4:0] phase_q, phase_d;

   always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
         phase_d = PH_IDLE;
      end else if (adv_i && !hold_i) begin
         phase_d = (phase_q == PH_IDLE) ? P1 : {phase_q[3:0], phase_q[4]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/pc_phase_seq.sv
// Multi-cycle instruction sequencer: owns PC, IR and SZCV, steps each
// instruction through five one-hot phases and handles run/stop/halt.
module pc_phase_seq
   import pc_phase_seq_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            exec,
   input  logic [15:0]     imem_data,
   input  logic            mem_wait,
   input  logic [3:0]      szcv_in,
   input  logic            szcv_we,
   input  logic            jflag,
   input  logic [PC_W-1:0] jdest,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     ir,
   output logic [3:0]      szcv,
   output logic [4:0]      phase,
   output logic            running,
   output logic            halted
);

   run_state_e      state_q, state_d;
   logic            stop_pend_q, stop_pend_d;
   logic            halted_q, halted_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [3:0]      szcv_q, szcv_d;

   logic [4:0] phase_w;
   logic       in_run, start, hold, stop_now, adv;

   assign in_run   = (state_q == ST_RUN);
   assign start    = (state_q == ST_IDLE) && exec;
   assign hold     = in_run && (phase_w == P4) && mem_wait;
   assign stop_now = in_run && (phase_w == P5) && (is_halt(ir_q) || stop_pend_q);
   assign adv      = start || (in_run && !stop_now);

   pc_phase_seq_phase_ring u_phase_ring (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .hold_i (hold),
      .clr_i  (stop_now),
      .phase_o(phase_w)
   );

   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      halted_d    = halted_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      szcv_d      = szcv_q;
      if (start) begin
         state_d  = ST_RUN;
         halted_d = 1'b0;
      end else if (in_run) begin
         // Ending P5 clears any pending stop, so an exec arriving then is dropped.
         if (stop_now) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
            halted_d    = is_halt(ir_q);
         end else if (exec) begin
            stop_pend_d = 1'b1;
         end
         if (phase_w == P1) ir_d = imem_data;
         if ((phase_w == P3) && szcv_we) szcv_d = szcv_in;
         if (phase_w == P5) begin
            pc_d = (jflag && !is_halt(ir_q)) ? jdest : pc_q + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         stop_pend_q <= 1'b0;
         halted_q    <= 1'b0;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         szcv_q      <= '0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
         halted_q    <= halted_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         szcv_q      <= szcv_d;
      end
   end

   assign pc      = pc_q;
   assign ir      = ir_q;
   assign szcv    = szcv_q;
   assign phase   = phase_w;
   assign running = in_run;
   assign halted  = halted_q;

endmodule
